mul_digit_scheduler: RTL and testbench

- Sequential controller that computes one unsigned WIDTH x WIDTH product by time-multiplexing a single external combinational 2x2-bit multiplier core.
- Splits each operand into 2-bit digits and drives one digit pair per cycle to the core.
- Shift-accumulates the 4-bit partial products into a 2*WIDTH result.
- Lets the generated 2-bit multiplier cores be reused for wider operands, with a valid/ready interface on both sides.

---
 rtl/mul_digit_scheduler_if.sv | 34 +++
 rtl/mul_digit_scheduler.sv | 130 +++++++++++++
 tb/tb_mul_digit_scheduler.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_digit_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_digit_scheduler_if
// Description : Operand/result handshake and 2x2 core bundle for the
//               digit-serial multiplier scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_digit_scheduler_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;
    logic [1:0]         core_a;
    logic [1:0]         core_b;
    logic [3:0]         core_p;

    // Environment side: supplies operands, consumes results, hosts the core.
    modport master (
        output in_valid, in_a, in_b, out_ready, core_p,
        input  in_ready, out_valid, out_p, core_a, core_b
    );

    // Scheduler side.
    modport slave (
        input  in_valid, in_a, in_b, out_ready, core_p,
        output in_ready, out_valid, out_p, core_a, core_b
    );
endinterface
`default_nettype wire

// File: rtl/mul_digit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mul_digit_scheduler
// Description : Computes an unsigned WIDTH x WIDTH product by stepping one
//               2-bit digit pair per cycle through an external combinational
//               2x2 multiplier and shift-accumulating the partial products.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_digit_scheduler #(
    parameter int WIDTH = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mul_digit_scheduler_if.slave bus
);

    localparam int D     = WIDTH / 2;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
    localparam int PW    = 2 * WIDTH;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(D - 1);

    // Operands are split into 2-bit digits, so only even widths make sense.
    if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
        $error("mul_digit_scheduler: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_i;          // A digit index, inner loop
    logic [IDX_W-1:0] r_j;          // B digit index, outer loop
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_out_p;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [1:0]       w_core_a;
    logic [1:0]       w_core_b;
    logic [IDX_W+1:0] w_shift;
    logic [PW-1:0]    w_pp;
    logic [PW-1:0]    w_sum;
    logic             w_last;

    // Partial product weight is 4^(i+j); shifting by 2*(i+j) places it exactly.
    assign w_shift = {1'b0, r_i, 1'b0} + {1'b0, r_j, 1'b0};
    assign w_pp    = PW'(bus.core_p) << w_shift;
    assign w_sum   = r_acc + w_pp;
    assign w_last  = (r_i == c_last_idx) && (r_j == c_last_idx);

    // Digit selection from the registered indices; core sees zeros outside RUN.
    always_comb begin
        w_core_a = 2'b00;
        w_core_b = 2'b00;
        if (r_state == S_RUN) begin
            w_core_a = r_a[{r_i, 1'b0} +: 2];
            w_core_b = r_b[{r_j, 1'b0} +: 2];
        end
    end

    assign bus.core_a    = w_core_a;
    assign bus.core_b    = w_core_b;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_p     = r_out_p;

    // Control FSM: accept, walk all D*D digit pairs, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_acc       <= '0;
            r_out_p     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.in_a;
                        r_b        <= bus.in_b;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_out_p     <= w_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_i == c_last_idx) begin
                        r_i <= '0;
                        r_j <= r_j + 1'b1;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                S_DONE: begin
                    // Result stays put until the consumer takes it; a new
                    // operand is only considered once back in IDLE.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_digit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_digit_scheduler
// Description : Self-checking bench for mul_digit_scheduler, WIDTH=8 and
//               WIDTH=2 instances, with a behavioural 2x2 core each.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_digit_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [15:0] q8[$];
    logic [3:0]  q2[$];

    mul_digit_scheduler_if #(.WIDTH(8)) b8 ();
    mul_digit_scheduler_if #(.WIDTH(2)) b2 ();

    // Behavioural 2x2 multiplier cores.
    assign b8.core_p = {2'b00, b8.core_a} * {2'b00, b8.core_b};
    assign b2.core_p = {2'b00, b2.core_a} * {2'b00, b2.core_b};

    mul_digit_scheduler #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    mul_digit_scheduler #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair to the WIDTH=8 instance; returns after the accept edge.
    task automatic accept8(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        while (b8.in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL accept8_ready: in_ready=%b required 1", b8.in_ready);
        end
        b8.in_valid = 1'b1;
        b8.in_a     = a;
        b8.in_b     = b;
        step();
        b8.in_valid = 1'b0;
        q8.push_back(16'(a) * 16'(b));
    endtask

    // Counts cycles from the accept edge until out_valid is seen (bounded).
    task automatic wait_out8(output int lat);
        lat = 0;
        while (b8.out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (b8.in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b need 1", b8.in_ready); end
        checks++; if (b8.out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b need 0", b8.out_valid); end
        checks++; if (b8.out_p !== 16'h0000)  begin errors++; $display("FAIL reset_out_p: got %h need 0000", b8.out_p); end
        checks++; if (b8.core_a !== 2'b00 || b8.core_b !== 2'b00) begin errors++; $display("FAIL reset_core: got a=%0d b=%0d need 0 0", b8.core_a, b8.core_b); end
        checks++; if (b2.in_ready !== 1'b1 || b2.out_valid !== 1'b0 || b2.out_p !== 4'h0) begin errors++; $display("FAIL reset_w2: ready=%b valid=%b p=%h need 1 0 0", b2.in_ready, b2.out_valid, b2.out_p); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_max();
        int lat;
        logic ready_bad;
        logic [15:0] e;
        b8.out_ready = 1'b1;
        accept8(8'hFF, 8'hFF);
        lat = 0;
        ready_bad = 1'b0;
        while (b8.out_valid !== 1'b1 && lat < 100) begin
            if (b8.in_ready !== 1'b0) ready_bad = 1'b1;
            step();
            lat++;
        end
        checks++; if (lat != 16) begin errors++; $display("FAIL max_latency: got %0d need 16", lat); end
        checks++; if (ready_bad !== 1'b0) begin errors++; $display("FAIL max_in_ready_run: in_ready rose during RUN, need 0"); end
        checks++; if (b8.in_ready !== 1'b0) begin errors++; $display("FAIL max_in_ready_done: got %b need 0", b8.in_ready); end
        e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        checks++; if (b8.out_p !== e || e !== 16'hFE01) begin errors++; $display("FAIL max_product: got %h need %h", b8.out_p, e); end
        step();
        checks++; if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin errors++; $display("FAIL max_return_idle: valid=%b ready=%b need 0 1", b8.out_valid, b8.in_ready); end
    endtask

    task automatic test_digits();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  ea;
        logic [1:0]  eb;
        logic [15:0] e;
        a = 8'd13;
        b = 8'd11;
        b8.out_ready = 1'b1;
        accept8(a, b);
        for (int k = 0; k < 16; k++) begin
            ea = a[2*(k%4) +: 2];
            eb = b[2*(k/4) +: 2];
            checks++;
            if (b8.core_a !== ea || b8.core_b !== eb) begin
                errors++;
                $display("FAIL digits_cycle%0d: core_a=%0d core_b=%0d need %0d %0d", k, b8.core_a, b8.core_b, ea, eb);
            end
            if (k == 2) begin
                b8.in_a = 8'hFF;
                b8.in_b = 8'hFF;
            end
            step();
        end
        e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        checks++; if (b8.out_valid !== 1'b1) begin errors++; $display("FAIL digits_valid: got %b need 1", b8.out_valid); end
        checks++; if (b8.out_p !== e || e !== 16'h008F) begin errors++; $display("FAIL digits_product: got %h need %h", b8.out_p, e); end
        step();
    endtask

    task automatic test_zero_msb();
        logic [7:0] av[2];
        logic [7:0] bv[2];
        int lat;
        logic [15:0] e;
        av[0] = 8'h00; bv[0] = 8'hA7;
        av[1] = 8'h80; bv[1] = 8'h01;
        b8.out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            accept8(av[t], bv[t]);
            wait_out8(lat);
            e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
            checks++; if (lat != 16) begin errors++; $display("FAIL zmsb%0d_latency: got %0d need 16", t, lat); end
            checks++; if (b8.out_p !== e) begin errors++; $display("FAIL zmsb%0d_product: got %h need %h", t, b8.out_p, e); end
            step();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] e;
        b8.out_ready = 1'b0;
        accept8(8'h12, 8'h34);
        wait_out8(lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL bp_latency: got %0d need 16", lat); end
        e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (b8.out_valid !== 1'b1 || b8.out_p !== e || b8.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b p=%h ready=%b need 1 %h 0", k, b8.out_valid, b8.out_p, b8.in_ready, e);
            end
            b8.in_valid = (k % 2 == 0);
            b8.in_a     = 8'(k + 1);
            b8.in_b     = 8'hEE;
            step();
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        checks++; if (b8.out_p !== 16'h03A8) begin errors++; $display("FAIL bp_product: got %h need 03a8", b8.out_p); end
        step();
        checks++; if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid=%b ready=%b need 0 1", b8.out_valid, b8.in_ready); end
        repeat (3) step();
        checks++; if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept: valid=%b ready=%b need 0 1", b8.out_valid, b8.in_ready); end
    endtask

    task automatic test_reset_mid_run();
        logic stale;
        int lat;
        logic [15:0] e;
        b8.out_ready = 1'b1;
        accept8(8'hFF, 8'hFF);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q8.delete();
        checks++; if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.out_p !== 16'h0000) begin errors++; $display("FAIL rmid_state: ready=%b valid=%b p=%h need 1 0 0000", b8.in_ready, b8.out_valid, b8.out_p); end
        stale = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (b8.out_valid !== 1'b0) stale = 1'b1;
            step();
        end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rmid_stale_valid: out_valid pulsed after reset, need none"); end
        accept8(8'h05, 8'h06);
        wait_out8(lat);
        e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        checks++; if (lat != 16) begin errors++; $display("FAIL rmid_latency: got %0d need 16", lat); end
        checks++; if (b8.out_p !== e || e !== 16'h001E) begin errors++; $display("FAIL rmid_product: got %h need %h", b8.out_p, e); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] av[2];
        logic [1:0] bv[2];
        int acc_cycle[2];
        int n_acc;
        int n_out;
        int cycle;
        logic prev_ov;
        logic accepting;
        logic [3:0] e;
        av[0] = 2'd3; bv[0] = 2'd3;
        av[1] = 2'd2; bv[1] = 2'd3;
        n_acc = 0; n_out = 0; cycle = 0; prev_ov = 1'b0;
        acc_cycle[0] = 0; acc_cycle[1] = 0;
        b2.out_ready = 1'b1;
        b2.in_valid  = 1'b1;
        b2.in_a      = av[0];
        b2.in_b      = bv[0];
        while ((n_acc < 2 || n_out < 2) && cycle < 50) begin
            if (b2.out_valid === 1'b1) begin
                e = (q2.size() > 0) ? q2.pop_front() : 4'hx;
                checks++; if (b2.out_p !== e) begin errors++; $display("FAIL b2b_product%0d: got %0d need %0d", n_out, b2.out_p, e); end
                checks++; if (prev_ov !== 1'b0) begin errors++; $display("FAIL b2b_valid_len%0d: out_valid held over 1 cycle", n_out); end
                n_out++;
            end
            prev_ov   = b2.out_valid;
            accepting = (b2.in_ready === 1'b1) && (b2.in_valid === 1'b1) && (n_acc < 2);
            if (accepting) begin
                q2.push_back(4'({2'b00, b2.in_a} * {2'b00, b2.in_b}));
                acc_cycle[n_acc] = cycle;
                n_acc++;
            end
            step();
            cycle++;
            if (accepting) begin
                if (n_acc < 2) begin
                    b2.in_a = av[n_acc];
                    b2.in_b = bv[n_acc];
                end else begin
                    b2.in_valid = 1'b0;
                end
            end
        end
        b2.in_valid = 1'b0;
        checks++; if (n_acc != 2 || n_out != 2) begin errors++; $display("FAIL b2b_count: accepts=%0d outputs=%0d need 2 2", n_acc, n_out); end
        checks++; if (acc_cycle[1] - acc_cycle[0] != 3) begin errors++; $display("FAIL b2b_spacing: got %0d need 3", acc_cycle[1] - acc_cycle[0]); end
    endtask

    initial begin
        b8.in_valid = 1'b0; b8.in_a = '0; b8.in_b = '0; b8.out_ready = 1'b0;
        b2.in_valid = 1'b0; b2.in_a = '0; b2.in_b = '0; b2.out_ready = 1'b0;
        test_reset();
        test_max();
        test_digits();
        test_zero_msb();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
